multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit for the MIPS datapath: a Moore/Mealy state machine that sequences each instruction through fetch, decode, execute, memory and write-back, and drives the shared-ALU, shared-memory datapath. It replaces the single-cycle opcode decoder. It adds memory wait-state handshaking, a bounded memory timeout, optional jump support and illegal-opcode reporting. It sits between the instruction register (opcode source) and all datapath muxes and enables.

## Interface
- SUPPORT_JUMP, 1: when 1, opcode 6'h2 (J) is legal; when 0 it is treated as illegal.
- MEM_TIMEOUT, 15: maximum consecutive cycles waiting on MemReady before abort; legal range 1..255.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears the FSM to FETCH and the wait counter to 0.
- OP  input  6  opcode from the instruction register; sampled in DECODE only.
- Zero  input  1  ALU zero flag; sampled in BRANCH.
- MemReady  input  1  memory completes the current access this cycle.
- PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  output  4  0 = R, 1 = ADDI, 2 = ORI, 3 = LUI, 4 = ANDI, 5 = BEQ, 6 = BNE, 7 = LW, 8 = SW, 9 = PC+4 add, 10 = branch-target add.
- State  output  4  current state encoding, for debug.
- IllegalOp  output  1  one-cycle pulse on an unsupported opcode.
- BusError  output  1  one-cycle pulse on a memory timeout.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9. Codes 10..15 are unreachable and return to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=9, PCSource=00.
  - IRWrite and PCWrite are asserted only when MemReady=1 (Mealy).
  - Advance to DECODE on MemReady.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=10 (branch target precomputed into ALUOut). OP is latched into op_q, and OP selects the next state:
  - 0x00, 0x08, 0x0d, 0x0f, 0x0c → EXEC.
  - 0x23, 0x2b → MEMADR.
  - 0x04, 0x05 → BRANCH.
  - 0x02 with SUPPORT_JUMP=1 → JUMP.
  - Any other opcode → FETCH with IllegalOp=1.
- EXEC: ALUSrcA=1. ALUSrcB=00 for R-type, 10 otherwise. ALUOp is taken from op_q. Next state ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1 for R-type else 0. Next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=7 (LW) or 8 (SW). Next state MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Advance to MEMWB on MemReady.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Advance to FETCH on MemReady.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=5 or 6, PCSource=01.
  - PCWrite = (BEQ & Zero) | (BNE & ~Zero).
  - Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- Any control not listed for a state is 0.
- Wait counter (8 bits):
  - Increments each cycle in FETCH, MEMRD or MEMWR while MemReady=0.
  - Clears on MemReady=1 and on every state change.
  - When it reaches MEM_TIMEOUT with MemReady still 0: BusError=1 for that cycle, memory strobes stay asserted, next state FETCH, counter cleared.
  - A timeout in FETCH re-fetches from the same PC, because PCWrite was never issued.
- MemReady=1 in the same cycle the counter reaches MEM_TIMEOUT counts as completion: no BusError.

## Timing
- Reset values: State=0 (FETCH), op_q=0, counter=0.
  - Combinational outputs during reset are the FETCH values with MemReady gating, so PCWrite and IRWrite stay 0 unless MemReady=1.
  - BusError=0 and IllegalOp=0 during reset.
- Reset deassertion is asynchronous at assert and takes effect at the next clk edge on release. An in-flight access is abandoned, with no further strobes after reset.
- Latency with MemReady tied 1:
  - R/I-ALU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE: 3 cycles.
  - J: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each memory wait cycle adds one cycle to FETCH, MEMRD or MEMWR.
- MemRead/MemWrite are held stable for the whole wait. No strobe toggles mid-access.
- IllegalOp and BusError are never asserted in the same cycle.

## Test plan
- Reset with MemReady=1, then OP=0x00 → State sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. ALUOp=0 in state 6.
- LW (OP=0x23), MemReady low for 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4,0. MemRead held in all MEMRD cycles. RegWrite=1 and MemtoReg=1 in state 4.
- BEQ with Zero=1 → PCWrite=1 and PCSource=01 in state 8. BNE with Zero=1 → PCWrite=0 in state 8.
- MEM_TIMEOUT=3, MemReady=0 in MEMWR for SW → BusError pulses on the 3rd wait cycle, then State=0. MemReady=1 exactly on the 3rd cycle → no BusError, normal return to FETCH.
- OP=0x02 with SUPPORT_JUMP=1 → JUMP, PCWrite=1, PCSource=10. With SUPPORT_JUMP=0, and also with OP=0x3f → IllegalOp pulse in DECODE, then State=0.
- reset driven low while in MEMRD → State=0 immediately, MemRead still asserted only via FETCH decode. Counter reads 0 after release.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Bus between the multi-cycle control FSM and the MIPS datapath.
// master: the control unit (receives OP/Zero/MemReady, drives all controls).
// slave : the datapath side (drives OP/Zero/MemReady, receives all controls).
// Signals:
//   OP[5:0], Zero, MemReady                      datapath -> control
//   PCWrite, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], PCSource[1:0], ALUOp[3:0]      control -> datapath
//   State[3:0], IllegalOp, BusError              control status / debug
interface multicycle_control_if;
    logic [5:0] OP;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] ALUOp;
    logic [3:0] State;
    logic       IllegalOp;
    logic       BusError;

    modport master (
        input  OP, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, State, IllegalOp,
               BusError
    );

    modport slave (
        output OP, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, State, IllegalOp,
               BusError
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit. Sequences each instruction through
// fetch/decode/execute/memory/write-back and drives the shared-ALU,
// shared-memory datapath. Memory accesses wait on MemReady and abort
// with a BusError pulse after MEM_TIMEOUT consecutive wait cycles.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (FSM -> FETCH, op/counter -> 0)
//   bus    multicycle_control_if.master (opcode/flags in, controls out)
// Parameters:
//   SUPPORT_JUMP  1 makes opcode 0x02 (J) legal, 0 reports it as illegal
//   MEM_TIMEOUT   wait cycles tolerated per memory access (1..255)
module multicycle_control #(
    parameter logic        SUPPORT_JUMP = 1'b1,
    parameter int unsigned MEM_TIMEOUT  = 32'd15
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    // The counter value seen during the MEM_TIMEOUT-th wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 32'd1);

    // ALU operation for the register/immediate ALU class.
    function automatic logic [3:0] exec_alu_op(input logic [5:0] op);
        case (op)
            OP_R:    return 4'd0;
            OP_ADDI: return 4'd1;
            OP_ORI:  return 4'd2;
            OP_LUI:  return 4'd3;
            OP_ANDI: return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    state_t     state_r;
    state_t     next_s;
    logic [5:0] op_r;
    logic [7:0] wait_r;
    logic [7:0] wait_next_s;
    logic       mem_state_s;
    logic       timeout_s;

    assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) ||
                         (state_r == S_MEMWR);
    // MemReady on the last allowed cycle still counts as completion.
    assign timeout_s   = mem_state_s && !bus.MemReady && (wait_r == WAIT_LAST);
    assign bus.State   = state_r;

    // Next-state and datapath control decode (Mealy gating on MemReady/Zero).
    always_comb begin
        next_s        = state_r;
        bus.PCWrite   = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegDst    = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.PCSource  = 2'b00;
        bus.ALUOp     = 4'd0;
        bus.IllegalOp = 1'b0;
        case (state_r)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 4'd9;
                if (bus.MemReady) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    next_s      = S_DECODE;
                end else begin
                    // A timeout simply re-fetches: the PC was never advanced.
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ALUOp   = 4'd10;
                case (bus.OP)
                    OP_R, OP_ADDI, OP_ORI, OP_LUI, OP_ANDI: next_s = S_EXEC;
                    OP_LW, OP_SW:                           next_s = S_MEMADR;
                    OP_BEQ, OP_BNE:                         next_s = S_BRANCH;
                    OP_J: begin
                        if (SUPPORT_JUMP) begin
                            next_s = S_JUMP;
                        end else begin
                            bus.IllegalOp = 1'b1;
                            next_s        = S_FETCH;
                        end
                    end
                    default: begin
                        bus.IllegalOp = 1'b1;
                        next_s        = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = (op_r == OP_R) ? 2'b00 : 2'b10;
                bus.ALUOp   = exec_alu_op(op_r);
                next_s      = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = (op_r == OP_R);
                next_s       = S_FETCH;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = (op_r == OP_SW) ? 4'd8 : 4'd7;
                next_s      = (op_r == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.MemReady) begin
                    next_s = S_MEMWB;
                end else if (timeout_s) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                next_s       = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.MemReady || timeout_s) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_MEMWR;
                end
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = (op_r == OP_BNE) ? 4'd6 : 4'd5;
                bus.PCSource = 2'b01;
                bus.PCWrite  = ((op_r == OP_BEQ) && bus.Zero) ||
                               ((op_r == OP_BNE) && !bus.Zero);
                next_s       = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                next_s       = S_FETCH;
            end
            default: begin
                next_s = S_FETCH;
            end
        endcase
        // The counter may sit at WAIT_LAST while reset is held; stay quiet then.
        bus.BusError = timeout_s && reset;
    end

    // Wait counter: counts consecutive not-ready memory cycles in one state.
    always_comb begin
        if (next_s != state_r) begin
            wait_next_s = 8'd0;
        end else if (timeout_s) begin
            wait_next_s = 8'd0;
        end else if (mem_state_s && !bus.MemReady) begin
            wait_next_s = wait_r + 8'd1;
        end else begin
            wait_next_s = 8'd0;
        end
    end

    // State, latched opcode and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
            op_r    <= 6'h00;
            wait_r  <= 8'd0;
        end else begin
            state_r <= next_s;
            wait_r  <= wait_next_s;
            if (state_r == S_DECODE) begin
                op_r <= bus.OP;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, pcs;
        logic [3:0] aop;
        logic       ill, berr;
    } ctl_t;

    // One expected cycle: inputs to drive and outputs required before the edge.
    typedef struct {
        logic       rst_on;
        logic       mr;
        logic [5:0] op;
        logic       zero;
        logic [3:0] st;
        ctl_t       c;
        string      tag;
    } cyc_t;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_control_if ifa();
    multicycle_control_if ifb();

    multicycle_control #(.SUPPORT_JUMP(1'b1), .MEM_TIMEOUT(3)) dut_a (
        .clk(clk), .reset(reset_a), .bus(ifa));
    multicycle_control #(.SUPPORT_JUMP(1'b0), .MEM_TIMEOUT(15)) dut_b (
        .clk(clk), .reset(reset_b), .bus(ifb));

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    function automatic ctl_t fetch_ctl();
        ctl_t c = '0;
        c.mrd = 1'b1;
        c.asb = 2'b01;
        c.aop = 4'd9;
        return c;
    endfunction

    task automatic push(input logic rst_on, input logic mr, input logic [5:0] op,
                        input logic zero, input logic [3:0] st, input ctl_t c,
                        input string tag);
        cyc_t e;
        e.rst_on = rst_on; e.mr = mr; e.op = op; e.zero = zero;
        e.st = st; e.c = c; e.tag = tag;
        q.push_back(e);
    endtask

    // Memory access of st with 'waits' not-ready cycles; ok=0 if it timed out.
    task automatic gen_access(input int to, input int waits, input logic [3:0] st,
                              input ctl_t base, input logic [1:0] done_bits,
                              input string tag, output bit ok);
        ctl_t c;
        for (int i = 1; i <= waits && i <= to; i++) begin
            c = base;
            c.berr = (i == to);
            push(1'b0, 1'b0, rnd_op(), rnd_bit(), st, c, {tag, "_wait"});
        end
        if (waits >= to) begin
            ok = 1'b0;
        end else begin
            c = base;
            {c.irw, c.pcw} = done_bits;
            push(1'b0, 1'b1, rnd_op(), rnd_bit(), st, c, tag);
            ok = 1'b1;
        end
    endtask

    // Whole instruction as the expected cycle trace, from the instruction rules.
    task automatic gen_inst(input int to, input bit jmp, input logic [5:0] op,
                            input logic zero, input int wf, input int wm);
        ctl_t c;
        bit   ok, is_alu, is_mem, is_br, is_j;
        gen_access(to, wf, 4'd0, fetch_ctl(), 2'b11, "fetch", ok);
        if (!ok) return;
        is_alu = (op == 6'h00) || (op == 6'h08) || (op == 6'h0d) ||
                 (op == 6'h0f) || (op == 6'h0c);
        is_mem = (op == 6'h23) || (op == 6'h2b);
        is_br  = (op == 6'h04) || (op == 6'h05);
        is_j   = (op == 6'h02) && jmp;
        c = '0; c.asb = 2'b11; c.aop = 4'd10;
        c.ill = !(is_alu || is_mem || is_br || is_j);
        push(1'b0, rnd_bit(), op, rnd_bit(), 4'd1, c, "decode");
        if (c.ill) return;
        if (is_alu) begin
            c = '0; c.asa = 1'b1;
            c.asb = (op == 6'h00) ? 2'b00 : 2'b10;
            case (op)
                6'h08:   c.aop = 4'd1;
                6'h0d:   c.aop = 4'd2;
                6'h0f:   c.aop = 4'd3;
                6'h0c:   c.aop = 4'd4;
                default: c.aop = 4'd0;
            endcase
            push(1'b0, rnd_bit(), rnd_op(), rnd_bit(), 4'd6, c, "exec");
            c = '0; c.rw = 1'b1; c.rdst = (op == 6'h00);
            push(1'b0, rnd_bit(), rnd_op(), rnd_bit(), 4'd7, c, "aluwb");
        end else if (is_mem) begin
            c = '0; c.asa = 1'b1; c.asb = 2'b10;
            c.aop = (op == 6'h23) ? 4'd7 : 4'd8;
            push(1'b0, rnd_bit(), rnd_op(), rnd_bit(), 4'd2, c, "memadr");
            c = '0; c.iord = 1'b1;
            if (op == 6'h23) begin
                c.mrd = 1'b1;
                gen_access(to, wm, 4'd3, c, 2'b00, "memrd", ok);
                if (ok) begin
                    c = '0; c.rw = 1'b1; c.m2r = 1'b1;
                    push(1'b0, rnd_bit(), rnd_op(), rnd_bit(), 4'd4, c, "memwb");
                end
            end else begin
                c.mwr = 1'b1;
                gen_access(to, wm, 4'd5, c, 2'b00, "memwr", ok);
            end
        end else if (is_br) begin
            c = '0; c.asa = 1'b1; c.pcs = 2'b01;
            c.aop = (op == 6'h04) ? 4'd5 : 4'd6;
            c.pcw = (op == 6'h04) ? zero : !zero;
            push(1'b0, rnd_bit(), rnd_op(), zero, 4'd8, c, "branch");
        end else begin
            c = '0; c.pcw = 1'b1; c.pcs = 2'b10;
            push(1'b0, rnd_bit(), rnd_op(), rnd_bit(), 4'd9, c, "jump");
        end
    endtask

    task automatic gen_reset();
        ctl_t c;
        c = fetch_ctl(); c.pcw = 1'b1; c.irw = 1'b1;
        push(1'b1, 1'b1, rnd_op(), rnd_bit(), 4'd0, c, "reset_ready");
        push(1'b1, 1'b0, rnd_op(), rnd_bit(), 4'd0, fetch_ctl(), "reset_idle");
    endtask

    // Drive each expected cycle on the falling edge and check before the rising edge.
    task automatic play(input int d);
        cyc_t       e;
        logic [3:0] st_o;
        ctl_t       c_o;
        string      pfx;
        pfx = (d == 0) ? "a_" : "b_";
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            if (d == 0) begin
                reset_a = ~e.rst_on; ifa.MemReady = e.mr; ifa.OP = e.op; ifa.Zero = e.zero;
            end else begin
                reset_b = ~e.rst_on; ifb.MemReady = e.mr; ifb.OP = e.op; ifb.Zero = e.zero;
            end
            #2;
            if (d == 0) begin
                st_o = ifa.State;
                c_o  = {ifa.PCWrite, ifa.IorD, ifa.MemRead, ifa.MemWrite, ifa.IRWrite,
                        ifa.MemtoReg, ifa.RegDst, ifa.RegWrite, ifa.ALUSrcA, ifa.ALUSrcB,
                        ifa.PCSource, ifa.ALUOp, ifa.IllegalOp, ifa.BusError};
            end else begin
                st_o = ifb.State;
                c_o  = {ifb.PCWrite, ifb.IorD, ifb.MemRead, ifb.MemWrite, ifb.IRWrite,
                        ifb.MemtoReg, ifb.RegDst, ifb.RegWrite, ifb.ALUSrcA, ifb.ALUSrcB,
                        ifb.PCSource, ifb.ALUOp, ifb.IllegalOp, ifb.BusError};
            end
            chk_eq({pfx, e.tag, "_state"}, 32'(st_o), 32'(e.st));
            chk_eq({pfx, e.tag, "_ctl"}, 32'(c_o), 32'(e.c));
        end
    endtask

    task automatic gen_random(input int to, input bit jmp);
        logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h0d, 6'h0f, 6'h0c,
                                 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
        logic [5:0] op;
        int         wf, wm, pick;
        pick = $urandom_range(0, 11);
        op   = (pick < 10) ? ops[pick] : rnd_op();
        wf   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, to) : $urandom_range(0, 1);
        wm   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, to) : $urandom_range(0, 1);
        gen_inst(to, jmp, op, rnd_bit(), wf, wm);
    endtask

    initial begin
        ctl_t c;
        reset_a = 1'b0; reset_b = 1'b0;
        ifa.MemReady = 1'b1; ifa.OP = 6'h00; ifa.Zero = 1'b0;
        ifb.MemReady = 1'b1; ifb.OP = 6'h00; ifb.Zero = 1'b0;

        // Instance A: jumps legal, 3-cycle memory timeout.
        gen_reset();
        gen_inst(3, 1'b1, 6'h00, 1'b0, 0, 0);   // R-type 0,1,6,7
        gen_inst(3, 1'b1, 6'h04, 1'b1, 0, 0);   // BEQ taken
        gen_inst(3, 1'b1, 6'h05, 1'b1, 0, 0);   // BNE not taken
        gen_inst(3, 1'b1, 6'h2b, 1'b0, 0, 3);   // SW times out in MEMWR
        gen_inst(3, 1'b1, 6'h2b, 1'b0, 0, 2);   // SW ready on the last cycle
        gen_inst(3, 1'b1, 6'h02, 1'b0, 0, 0);   // J
        gen_inst(3, 1'b1, 6'h3f, 1'b0, 0, 0);   // illegal
        gen_inst(3, 1'b1, 6'h0f, 1'b0, 3, 0);   // fetch timeout
        gen_inst(3, 1'b1, 6'h0f, 1'b0, 2, 0);   // LUI after ready on last fetch cycle
        // LW interrupted by reset in MEMRD.
        c = fetch_ctl(); c.pcw = 1'b1; c.irw = 1'b1;
        push(1'b0, 1'b1, rnd_op(), 1'b0, 4'd0, c, "lw_fetch");
        c = '0; c.asb = 2'b11; c.aop = 4'd10;
        push(1'b0, 1'b1, 6'h23, 1'b0, 4'd1, c, "lw_decode");
        c = '0; c.asa = 1'b1; c.asb = 2'b10; c.aop = 4'd7;
        push(1'b0, 1'b0, rnd_op(), 1'b0, 4'd2, c, "lw_memadr");
        c = '0; c.iord = 1'b1; c.mrd = 1'b1;
        push(1'b0, 1'b0, rnd_op(), 1'b0, 4'd3, c, "lw_memrd_wait");
        push(1'b0, 1'b0, rnd_op(), 1'b0, 4'd3, c, "lw_memrd_wait");
        push(1'b1, 1'b0, rnd_op(), 1'b0, 4'd0, fetch_ctl(), "midrd_reset");
        gen_inst(3, 1'b1, 6'h08, 1'b0, 3, 0);   // counter restarts from 0
        gen_inst(3, 1'b1, 6'h0c, 1'b0, 0, 0);
        play(0);
        for (int i = 0; i < 40; i++) begin
            gen_random(3, 1'b1);
            play(0);
        end

        // Instance B: jumps illegal, 15-cycle memory timeout.
        gen_reset();
        gen_inst(15, 1'b0, 6'h23, 1'b0, 0, 3);  // LW 0,1,2,3,3,3,3,4
        gen_inst(15, 1'b0, 6'h02, 1'b0, 0, 0);  // J is illegal here
        gen_inst(15, 1'b0, 6'h0d, 1'b0, 15, 0); // fetch timeout
        gen_inst(15, 1'b0, 6'h2b, 1'b0, 1, 14); // SW completes on the last cycle
        play(1);
        for (int i = 0; i < 30; i++) begin
            gen_random(15, 1'b0);
            play(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
